// File: rtl/regfile_pkg.sv
// Shared defaults and word/address types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREGS_RV32E  = 16;

  typedef logic [$clog2(NREGS_RV32E)-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]        xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per architectural register.
// A claim sets a bit, a committed write clears it, and a claim beats a write
// to the same register in the same cycle. Bit 0 never becomes busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_RV32E,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                 claim_en,
  input  logic [AW-1:0]        claim_addr,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Next busy state: clears from writes first, then the claim so it wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (claim_en && (claim_addr != '0)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (rst) begin
      busy_d = '0;
    end
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// busy-bit scoreboard. Register 0 reads as zero and is never stored.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_RV32E,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0] mem_q [NREGS-1:1];
  logic [XLEN-1:0] mem_d [NREGS-1:1];

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .AW     (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

  // Next storage state: ports applied in ascending order so the highest wins.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
    if (rst) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        mem_d[r] = '0;
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read ports with optional same-cycle bypass of data and busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy_vec[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int unsigned j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
              rd_busy[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (32-bit, 16 regs, 2 read, 2 write, bypass)
// and instance B (64-bit, 32 regs, 4 read, 2 write, no bypass) share stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  ra [4];
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [63:0] wd [2];
  logic        ce;
  logic [4:0]  ca;

  logic [7:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic [7:0]   a_wr_addr;
  logic [63:0]  a_wr_data;
  logic [3:0]   a_claim_addr;
  logic [15:0]  a_busy_vec;

  logic [19:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [9:0]   b_wr_addr;
  logic [127:0] b_wr_data;
  logic [4:0]   b_claim_addr;
  logic [31:0]  b_busy_vec;

  always_comb begin
    a_rd_addr    = {ra[1][3:0], ra[0][3:0]};
    a_wr_addr    = {wa[1][3:0], wa[0][3:0]};
    a_wr_data    = {wd[1][31:0], wd[0][31:0]};
    a_claim_addr = ca[3:0];
    b_rd_addr    = {ra[3], ra[2], ra[1], ra[0]};
    b_wr_addr    = {wa[1], wa[0]};
    b_wr_data    = {wd[1], wd[0]};
    b_claim_addr = ca;
  end

  regfile_mp #(
    .XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(we), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .claim_en(ce),
    .claim_addr(a_claim_addr), .busy_vec(a_busy_vec)
  );

  regfile_mp #(
    .XLEN(64), .NREGS(32), .NREAD(4), .NWRITE(2), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(we), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .claim_en(ce),
    .claim_addr(b_claim_addr), .busy_vec(b_busy_vec)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural contents and pending bits per instance.
  logic [63:0] mreg  [2][32];
  bit          mbusy [2][32];
  bit          seen_rst = 1'b0;

  function automatic int unsigned nregs_of(input int k);
    return (k == 0) ? 16 : 32;
  endfunction

  function automatic logic [63:0] dmask(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic model_read(input int k, input logic [4:0] addr_in,
                            output logic [63:0] d, output logic b);
    int unsigned a;
    a = 32'(addr_in) % nregs_of(k);
    d = '0;
    b = 1'b0;
    if (a != 0) begin
      d = mreg[k][a];
      b = mbusy[k][a];
      if (k == 0) begin
        for (int j = 0; j < 2; j++) begin
          if (we[j] && (32'(wa[j]) % nregs_of(k)) == a) begin
            d = wd[j] & dmask(k);
            b = 1'b0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mreg[k][r]  <= '0;
          mbusy[k][r] <= 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (we[j] && (32'(wa[j]) % nregs_of(k)) != 0) begin
            mreg[k][32'(wa[j]) % nregs_of(k)]  <= wd[j] & dmask(k);
            mbusy[k][32'(wa[j]) % nregs_of(k)] <= 1'b0;
          end
        end
        if (ce && (32'(ca) % nregs_of(k)) != 0) begin
          mbusy[k][32'(ca) % nregs_of(k)] <= 1'b1;
        end
      end
    end
    if (rst) seen_rst <= 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (seen_rst) begin
      logic [63:0] ed;
      logic        eb;
      logic [31:0] ebv;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < ((k == 0) ? 2 : 4); i++) begin
          model_read(k, ra[i], ed, eb);
          if (k == 0) begin
            check($sformatf("A.rd_data[%0d]", i), {32'b0, a_rd_data[i*32 +: 32]}, ed);
            check($sformatf("A.rd_busy[%0d]", i), {63'b0, a_rd_busy[i]}, {63'b0, eb});
          end else begin
            check($sformatf("B.rd_data[%0d]", i), b_rd_data[i*64 +: 64], ed);
            check($sformatf("B.rd_busy[%0d]", i), {63'b0, b_rd_busy[i]}, {63'b0, eb});
          end
        end
        ebv = '0;
        for (int r = 0; r < 32; r++) begin
          if (r < int'(nregs_of(k))) ebv[r] = mbusy[k][r];
        end
        if (k == 0) check("A.busy_vec", {48'b0, a_busy_vec}, {32'b0, ebv});
        else        check("B.busy_vec", {32'b0, b_busy_vec}, {32'b0, ebv});
      end
    end
  end

  task automatic idle();
    rst = 1'b0; we = '0; ce = 1'b0; ca = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    for (int j = 0; j < 2; j++) begin
      wa[j] = '0;
      wd[j] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  xword_t x5_exp = 32'h1234_5678;

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Sweep every address on every port after reset.
    for (int a = 0; a < 32; a++) begin
      for (int i = 0; i < 4; i++) ra[i] = 5'(a + i);
      mid();
      step();
    end
    check("reset A.busy_vec", {48'b0, a_busy_vec}, 64'h0);
    check("reset B.busy_vec", {32'b0, b_busy_vec}, 64'h0);

    // Two writes to x5 in one cycle: port 1 wins.
    idle();
    we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5;
    wd[0] = 64'h0BAD_F00D_DEAD_BEEF; wd[1] = 64'hCAFE_0000_1234_5678;
    ra[0] = 5'd5;
    mid();
    check("x5 bypass A", {32'b0, a_rd_data[31:0]}, {32'b0, x5_exp});
    check("x5 nobypass B", b_rd_data[63:0], 64'h0);
    step();
    idle();
    ra[0] = 5'd5;
    mid();
    check("x5 next A", {32'b0, a_rd_data[31:0]}, 64'h1234_5678);
    check("x5 next B", b_rd_data[63:0], 64'hCAFE_0000_1234_5678);
    step();

    // x0 write and claim are both ignored.
    idle();
    we = 2'b01; wa[0] = 5'd0; wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ce = 1'b1; ca = 5'd0;
    mid();
    check("x0 read A", {32'b0, a_rd_data[31:0]}, 64'h0);
    step();
    idle();
    mid();
    check("x0 busy A", {63'b0, a_busy_vec[0]}, 64'h0);
    check("x0 busy B", {63'b0, b_busy_vec[0]}, 64'h0);
    step();

    // Claim x7, then write it.
    idle();
    ce = 1'b1; ca = 5'd7;
    step();
    idle();
    ra[1] = 5'd7;
    mid();
    check("x7 claimed A", {63'b0, a_rd_busy[1]}, 64'h1);
    check("x7 claimed B", {63'b0, b_rd_busy[1]}, 64'h1);
    step();
    we = 2'b01; wa[0] = 5'd7; wd[0] = 64'h77;
    mid();
    check("x7 write A", {63'b0, a_rd_busy[1]}, 64'h0);
    check("x7 write B", {63'b0, b_rd_busy[1]}, 64'h1);
    step();
    idle();
    ra[1] = 5'd7;
    mid();
    check("x7 after B", {63'b0, b_rd_busy[1]}, 64'h0);
    step();

    // Claim and write x3 together: data lands, busy stays.
    idle();
    ce = 1'b1; ca = 5'd3; we = 2'b01; wa[0] = 5'd3; wd[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    step();
    idle();
    ra[0] = 5'd3;
    mid();
    check("x3 data A", {32'b0, a_rd_data[31:0]}, 64'hA5A5_A5A5);
    check("x3 busy A", {63'b0, a_busy_vec[3]}, 64'h1);
    check("x3 data B", b_rd_data[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
    check("x3 busy B", {63'b0, b_busy_vec[3]}, 64'h1);
    step();

    // Fill every register and claim a few, then reset alongside a write to x2.
    for (int a = 1; a < 32; a++) begin
      idle();
      we = 2'b01; wa[0] = 5'(a); wd[0] = {32'(a) ^ 32'h5A00_0000, 32'(a) * 32'h0101_0101};
      ce = (a % 3) == 0; ca = 5'(31 - a);
      for (int i = 0; i < 4; i++) ra[i] = 5'(a - 1 + 8 * i);
      step();
    end
    idle();
    rst = 1'b1; we = 2'b01; wa[0] = 5'd2; wd[0] = 64'h2222_2222_2222_2222;
    step();
    idle();
    ra[0] = 5'd2; ra[1] = 5'd15; ra[2] = 5'd31; ra[3] = 5'd30;
    mid();
    check("post-rst A x2", {32'b0, a_rd_data[31:0]}, 64'h0);
    check("post-rst B x31", b_rd_data[191:128], 64'h0);
    check("post-rst A.busy_vec", {48'b0, a_busy_vec}, 64'h0);
    check("post-rst B.busy_vec", {32'b0, b_busy_vec}, 64'h0);
    step();

    // Mixed traffic checked against the model every cycle.
    for (int n = 0; n < 60; n++) begin
      idle();
      we = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wa[j] = 5'($urandom_range(0, 31));
        wd[j] = {$urandom, $urandom};
      end
      ce = 1'($urandom_range(0, 1));
      ca = 5'($urandom_range(0, 31));
      for (int i = 0; i < 4; i++) ra[i] = (i == 0) ? wa[1] : 5'($urandom_range(0, 31));
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a busy-bit scoreboard. It replaces the single-write, dual-read RV32E register file so that wider-issue and multi-writeback pipelines can share one block. Register count, data width and the number of read and write ports are configurable. An optional same-cycle write-to-read bypass is provided, along with per-register pending-producer tracking. Register 0 is hardwired to zero. The block sits between decode/operand-fetch (read ports, claims) and writeback (write ports).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 16, architectural register count (16 for RV32E, 32 for RV32I); power of two, ≥2
- NREAD, 2, number of read ports
- NWRITE, 1, number of write ports
- BYPASS, 1, 1 = a read sees a same-cycle write; 0 = a read sees only registered state
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NREAD×AW  read addresses
- rd_data  out  NREAD×XLEN  read data
- rd_busy  out  NREAD  register has an outstanding producer
- wr_en  in  NWRITE  write enables
- wr_addr  in  NWRITE×AW  write addresses
- wr_data  in  NWRITE×XLEN  write data
- claim_en  in  1  mark a destination register as pending
- claim_addr  in  AW  register to mark pending
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0

## Operation
- Storage: NREGS-1 registers of XLEN bits (index 1..NREGS-1). Index 0 is not stored.
- Reads are combinational:
  - Reading address 0 returns 0 and rd_busy=0.
  - Otherwise rd_data is the stored value. If BYPASS=1 and any wr_en[j] targets the same address this cycle, rd_data is the wr_data of the highest-index such j.
- Writes commit at posedge clk when wr_en[j]=1 and wr_addr[j]≠0. Writes to address 0 are discarded.
- Multiple writes to the same address in one cycle: the highest port index wins.
- Scoreboard:
  - claim_en with claim_addr≠0 sets busy[claim_addr] at the next edge.
  - A committed write to address a clears busy[a] at the next edge.
  - Claim and write to the same address in the same cycle: the claim wins, so busy stays set (a new producer supersedes the old one).
  - claim_addr=0 is ignored.
- rd_busy[i] = busy[rd_addr[i]]. If BYPASS=1, rd_busy[i] is also forced to 0 when a same-cycle write hits that address.
- Reset: all registers are 0 and all busy bits are 0. Reset overrides any write or claim in the same cycle.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write latency: visible on the registered path one cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- Scoreboard latency: a claim at edge N shows busy from cycle N+1. A write at edge N clears busy from cycle N+1, or in the same cycle via rd_busy when BYPASS=1.
- Reset values: rd_data=0 for every address, rd_busy=0, busy_vec=0.
- Reset asserted mid-operation: the state clears at the next edge. Writes and claims presented in that cycle are lost.
- No handshake is involved: all inputs are sampled every cycle and there is no backpressure.

## Structure
- regfile_pkg provides:
  - the defaults XLEN_DEFAULT=32 and NREGS_RV32E=16
  - the typedefs reg_addr_t and xword_t
- Sub-module regfile_scoreboard (params NREGS, NWRITE) contains busy_vec, the claim/clear priority logic and the reset.
- regfile_mp instantiates regfile_scoreboard and contains the storage array, the write priority logic and the per-port bypass mux.

## Test plan
- Reset, then read every address on all ports -> every rd_data is 0, every rd_busy is 0, and busy_vec is 0.
- Write 0xDEADBEEF to x5 on port 0 and 0x12345678 to x5 on port 1 in the same cycle (NWRITE=2) -> the next cycle reads 0x12345678. With BYPASS=1, rd_addr=5 reads 0x12345678 in the write cycle itself.
- Write 0xFFFFFFFF to x0 -> a read of x0 returns 0, and a claim on x0 leaves busy_vec[0]=0.
- Claim x7 -> rd_busy=1 next cycle. Writing x7 clears it: rd_busy=0 in the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
- Claim x3 and write 0xA5A5A5A5 to x3 in the same cycle -> x3 holds 0xA5A5A5A5 and busy_vec[3] stays 1.
- Load x1..x15 with nonzero values, then assert rst together with a write to x2 -> one cycle later all reads return 0 and busy_vec is 0. Repeat with NREGS=32, XLEN=64, NREAD=4.
